// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch sequencer: fetch state, buffered
// {pc, instr} entry and the end-of-memory address test.
package fetch_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        END   = 2'd1,
        FAULT = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    localparam int INSTR_BYTES = 4;
    localparam int COUNT_W     = 4;

    // True when the word starting at addr does not lie fully inside memory.
    // Callers only pass aligned addresses, so addr + 3 cannot wrap.
    function automatic logic past_end(input logic [63:0] addr, input logic [63:0] mem_size);
        return (addr + 64'(INSTR_BYTES - 1)) >= mem_size;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// In-order prefetch buffer of {pc, instr} entries with a combinational head.
// Flush overrides push and pop in the same cycle.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               push,
    input  logic               pop,
    input  logic               flush,
    input  fetch_entry_t       push_data,
    output fetch_entry_t       head,
    output logic [COUNT_W-1:0] count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
    localparam logic [COUNT_W-1:0] FULL_COUNT = COUNT_W'(DEPTH);

    logic [PW-1:0]      wr_ptr_reg, wr_ptr_next;
    logic [PW-1:0]      rd_ptr_reg, rd_ptr_next;
    logic [COUNT_W-1:0] count_reg, count_next;
    logic               do_push, do_pop;
    fetch_entry_t       entry_q [DEPTH];

    always_comb begin
        do_pop      = pop && !flush && (count_reg != '0);
        // A full buffer accepts a push only when the head leaves in the same cycle.
        do_push     = push && !flush && ((count_reg != FULL_COUNT) || do_pop);
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (flush) begin
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            count_next  = '0;
        end else begin
            if (do_push) begin
                wr_ptr_next = (wr_ptr_reg == LAST) ? '0 : wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_next = (rd_ptr_reg == LAST) ? '0 : rd_ptr_reg + 1'b1;
            end
            count_next = count_reg + COUNT_W'(do_push) - COUNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            fetch_entry_t entry_reg;

            always_ff @(posedge clk) begin
                if (do_push && (wr_ptr_reg == PW'(gi))) begin
                    entry_reg <= push_data;
                end
            end

            assign entry_q[gi] = entry_reg;
        end
    endgenerate

    assign head  = entry_q[rd_ptr_reg];
    assign count = count_reg;

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Fetch sequencer: owns the PC, reads the combinational instruction ROM one word
// per cycle into the prefetch buffer, and applies redirects and END/FAULT stops.
module imem_fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int MEM_SIZE = 1024,
    parameter int DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic [63:0] imem_addr,
    input  logic [31:0] imem_instr,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        out_valid,
    output logic [63:0] out_pc,
    output logic [31:0] out_instr,
    input  logic        out_ready,
    output logic        fault,
    output logic        at_end
);

    localparam logic [63:0] MEM_LIMIT  = 64'(MEM_SIZE);
    localparam logic [63:0] STEP       = 64'(INSTR_BYTES);
    localparam logic [COUNT_W-1:0] FULL_COUNT = COUNT_W'(DEPTH);

    fetch_state_t       st, st_next;
    logic [63:0]        pc_reg, pc_next, pc_plus4;
    logic               fault_reg, fault_next;
    logic               at_end_reg, at_end_next;
    logic               push, pop;
    logic [COUNT_W-1:0] fifo_count;
    fetch_entry_t       fifo_head, push_data;

    assign out_valid = (fifo_count != '0);
    assign pc_plus4  = pc_reg + STEP;
    assign push_data = '{pc: pc_reg, instr: imem_instr};

    always_comb begin
        st_next     = st;
        pc_next     = pc_reg;
        fault_next  = fault_reg;
        at_end_next = at_end_reg;
        pop         = out_valid && out_ready;
        push        = (st == RUN) && !redirect_valid && ((fifo_count != FULL_COUNT) || pop);

        // A redirect discards everything in flight, including this cycle's pop.
        if (redirect_valid) begin
            pc_next     = redirect_pc;
            at_end_next = 1'b0;
            if (redirect_pc[1:0] != 2'b00) begin
                st_next    = FAULT;
                fault_next = 1'b1;
            end else if (past_end(redirect_pc, MEM_LIMIT)) begin
                st_next     = END;
                at_end_next = 1'b1;
                fault_next  = 1'b0;
            end else begin
                st_next    = RUN;
                fault_next = 1'b0;
            end
        end else if (push) begin
            pc_next = pc_plus4;
            if (past_end(pc_plus4, MEM_LIMIT)) begin
                st_next     = END;
                at_end_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            st         <= RUN;
            pc_reg     <= '0;
            fault_reg  <= 1'b0;
            at_end_reg <= 1'b0;
        end else begin
            st         <= st_next;
            pc_reg     <= pc_next;
            fault_reg  <= fault_next;
            at_end_reg <= at_end_next;
        end
    end

    fetch_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .pop      (pop),
        .flush    (redirect_valid),
        .push_data(push_data),
        .head     (fifo_head),
        .count    (fifo_count)
    );

    assign imem_addr = pc_reg;
    assign out_pc    = out_valid ? fifo_head.pc : '0;
    assign out_instr = out_valid ? fifo_head.instr : '0;
    assign fault     = fault_reg;
    assign at_end    = at_end_reg;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Bench for imem_fetch_ctrl: directed vector table, then randomized traffic
// compared against a queue-based reference model.
module tb_imem_fetch_ctrl;

    localparam int MEM   = 1024;
    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] imem_addr;
    logic [31:0] imem_instr;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        out_valid;
    logic [63:0] out_pc;
    logic [31:0] out_instr;
    logic        out_ready;
    logic        fault;
    logic        at_end;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [31:0] rom [MEM/4];

    always #5 clk = ~clk;

    imem_fetch_ctrl #(.MEM_SIZE(MEM), .DEPTH(DEPTH)) dut (
        .clk           (clk),
        .reset         (reset),
        .imem_addr     (imem_addr),
        .imem_instr    (imem_instr),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .out_valid     (out_valid),
        .out_pc        (out_pc),
        .out_instr     (out_instr),
        .out_ready     (out_ready),
        .fault         (fault),
        .at_end        (at_end)
    );

    function automatic logic [31:0] rom_word(input logic [63:0] addr);
        if (addr < 64'(MEM)) return rom[addr[9:2]];
        return 32'hDEAD_BEEF;
    endfunction

    always_comb imem_instr = rom_word(imem_addr);

    // Reference model: a queue of fetched words plus PC and stop mode.
    typedef struct {
        logic [63:0] pc;
        logic [31:0] instr;
    } m_entry_t;

    m_entry_t    mq[$];
    logic [63:0] m_pc;
    int          m_mode;   // 0 running, 1 stopped at end, 2 faulted
    logic        m_fault;
    logic        m_at_end;

    task automatic model_update(input logic r, input logic rv, input logic [63:0] rpc,
                                input logic rdy);
        if (r) begin
            mq.delete();
            m_pc = 0; m_mode = 0; m_fault = 0; m_at_end = 0;
            return;
        end
        if (rv) begin
            mq.delete();
            m_pc     = rpc;
            m_at_end = 0;
            if (rpc % 4 != 0) begin
                m_mode = 2; m_fault = 1;
            end else if (rpc + 3 >= 64'(MEM)) begin
                m_mode = 1; m_at_end = 1; m_fault = 0;
            end else begin
                m_mode = 0; m_fault = 0;
            end
            return;
        end
        if (rdy && mq.size() > 0) void'(mq.pop_front());
        if (m_mode == 0 && mq.size() < DEPTH) begin
            mq.push_back('{m_pc, rom_word(m_pc)});
            m_pc = m_pc + 4;
            if (m_pc + 3 >= 64'(MEM)) begin
                m_mode = 1; m_at_end = 1;
            end
        end
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=0x%0h required=0x%0h", name, cyc, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic rv, input logic [63:0] rpc, input logic rdy);
        reset          = r;
        redirect_valid = rv;
        redirect_pc    = rpc;
        out_ready      = rdy;
        model_update(r, rv, rpc, rdy);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic compare_model();
        logic        e_valid;
        logic [63:0] e_pc;
        logic [31:0] e_instr;
        e_valid = (mq.size() > 0);
        e_pc    = e_valid ? mq[0].pc : 64'd0;
        e_instr = e_valid ? mq[0].instr : 32'd0;
        chk("rnd_valid", 64'(out_valid), 64'(e_valid));
        chk("rnd_pc", out_pc, e_pc);
        chk("rnd_instr", 64'(out_instr), 64'(e_instr));
        chk("rnd_addr", imem_addr, m_pc);
        chk("rnd_fault", 64'(fault), 64'(m_fault));
        chk("rnd_at_end", 64'(at_end), 64'(m_at_end));
    endtask

    typedef struct {
        logic        rst;
        logic        rv;
        logic [63:0] rpc;
        logic        rdy;
        logic        e_valid;
        logic [63:0] e_pc;
        logic [63:0] e_addr;
        logic        e_at_end;
        logic        e_fault;
    } vec_t;

    function automatic vec_t mk(input logic rst, input logic rv, input logic [63:0] rpc,
                                input logic rdy, input logic e_valid, input logic [63:0] e_pc,
                                input logic [63:0] e_addr, input logic e_at_end,
                                input logic e_fault);
        vec_t v;
        v.rst = rst; v.rv = rv; v.rpc = rpc; v.rdy = rdy;
        v.e_valid = e_valid; v.e_pc = e_pc; v.e_addr = e_addr;
        v.e_at_end = e_at_end; v.e_fault = e_fault;
        return v;
    endfunction

    vec_t vecs [29];

    initial begin
        for (int i = 0; i < MEM/4; i++) rom[i] = $urandom;

        //            rst rv  rpc     rdy  valid pc      addr    end flt
        vecs[0]  = mk(1, 0, 0,      1,   0, 0,      0,      0, 0);
        vecs[1]  = mk(0, 0, 0,      0,   1, 0,      4,      0, 0);
        vecs[2]  = mk(0, 0, 0,      0,   1, 0,      8,      0, 0);
        vecs[3]  = mk(0, 0, 0,      0,   1, 0,      8,      0, 0);
        vecs[4]  = mk(0, 0, 0,      0,   1, 0,      8,      0, 0);
        vecs[5]  = mk(0, 0, 0,      0,   1, 0,      8,      0, 0);
        vecs[6]  = mk(0, 0, 0,      1,   1, 4,      12,     0, 0);
        vecs[7]  = mk(0, 0, 0,      1,   1, 8,      16,     0, 0);
        vecs[8]  = mk(0, 1, 'h40,   1,   0, 0,      'h40,   0, 0);
        vecs[9]  = mk(0, 0, 0,      1,   1, 'h40,   'h44,   0, 0);
        vecs[10] = mk(0, 0, 0,      1,   1, 'h44,   'h48,   0, 0);
        vecs[11] = mk(0, 1, 'h3FC,  0,   0, 0,      'h3FC,  0, 0);
        vecs[12] = mk(0, 0, 0,      0,   1, 'h3FC,  'h400,  1, 0);
        vecs[13] = mk(0, 0, 0,      0,   1, 'h3FC,  'h400,  1, 0);
        vecs[14] = mk(0, 0, 0,      1,   0, 0,      'h400,  1, 0);
        vecs[15] = mk(0, 0, 0,      1,   0, 0,      'h400,  1, 0);
        vecs[16] = mk(0, 1, 'h3FE,  1,   0, 0,      'h3FE,  0, 1);
        vecs[17] = mk(0, 0, 0,      1,   0, 0,      'h3FE,  0, 1);
        vecs[18] = mk(0, 1, 0,      1,   0, 0,      0,      0, 0);
        vecs[19] = mk(0, 0, 0,      1,   1, 0,      4,      0, 0);
        vecs[20] = mk(0, 0, 0,      1,   1, 4,      8,      0, 0);
        vecs[21] = mk(0, 1, 'h80,   1,   0, 0,      'h80,   0, 0);
        vecs[22] = mk(0, 0, 0,      1,   1, 'h80,   'h84,   0, 0);
        vecs[23] = mk(1, 1, 'h100,  1,   0, 0,      0,      0, 0);
        vecs[24] = mk(0, 0, 0,      1,   1, 0,      4,      0, 0);
        vecs[25] = mk(0, 0, 0,      1,   1, 4,      8,      0, 0);
        vecs[26] = mk(0, 1, 'h400,  1,   0, 0,      'h400,  1, 0);
        vecs[27] = mk(0, 0, 0,      1,   0, 0,      'h400,  1, 0);
        vecs[28] = mk(0, 1, 'h10,   1,   0, 0,      'h10,   0, 0);

        reset = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b0;

        for (int i = 0; i < 29; i++) begin
            logic [31:0] e_instr;
            step(vecs[i].rst, vecs[i].rv, vecs[i].rpc, vecs[i].rdy);
            e_instr = vecs[i].e_valid ? rom_word(vecs[i].e_pc) : 32'd0;
            chk("tv_valid", 64'(out_valid), 64'(vecs[i].e_valid));
            chk("tv_pc", out_pc, vecs[i].e_pc);
            chk("tv_instr", 64'(out_instr), 64'(e_instr));
            chk("tv_addr", imem_addr, vecs[i].e_addr);
            chk("tv_at_end", 64'(at_end), 64'(vecs[i].e_at_end));
            chk("tv_fault", 64'(fault), 64'(vecs[i].e_fault));
            $display("vec %0d: valid=%0d pc=0x%0h addr=0x%0h at_end=%0d fault=%0d",
                     i, out_valid, out_pc, imem_addr, at_end, fault);
        end

        // Hand sequence: walk to the last word from 0x3F0 with the head stalled.
        step(0, 1, 'h3F0, 0);
        for (int i = 0; i < 6; i++) step(0, 0, 0, (i >= 3));
        compare_model();
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0, 1);
            compare_model();
        end

        // Randomized traffic against the reference model.
        step(1, 0, 0, 0);
        compare_model();
        for (int n = 0; n < 4000; n++) begin
            logic        r, rv, rdy;
            logic [63:0] rpc;
            r   = ($urandom_range(0, 299) == 0);
            rv  = ($urandom_range(0, 11) == 0);
            rdy = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 4))
                0: rpc = 64'($urandom_range(0, 255)) << 2;
                1: rpc = 64'h3E0 + (64'($urandom_range(0, 7)) << 2);
                2: rpc = (64'($urandom_range(0, 255)) << 2) + 64'($urandom_range(1, 3));
                3: rpc = {$urandom, $urandom} & ~64'd3;
                default: rpc = 64'd0;
            endcase
            step(r, rv, rpc, rdy);
            compare_model();
            if (n % 500 == 0)
                $display("rnd %0d: valid=%0d pc=0x%0h addr=0x%0h at_end=%0d fault=%0d",
                         n, out_valid, out_pc, imem_addr, at_end, fault);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
